// File: rtl/cpu_types_pkg.sv
// Shared CPU types.
//   word_t        : 32-bit machine word
//   fetch_state_t : fetch-stage control states
//   NOP_INSTR     : encoding of SLL $0,$0,0, used as the pipeline bubble
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC and the instruction-memory request, keeps a one-entry hold
// buffer for an instruction that returns while IF/ID is stalled, and handles
// taken branch/jump redirects and halt.
//
// Ports:
//   CLK, RST       clock (rising edge), synchronous active-high reset
//   ihit, iload    instruction memory response for iaddr this cycle
//   iREN, iaddr    instruction memory request
//   stall          IF/ID must hold this cycle
//   redirect(_addr) taken branch/jump and its target
//   halt           halt has reached writeback
//   instr_out, pc_4_out, instr_valid, flush_out  to IF/ID
//   fetch_count    saturating count of instructions handed to IF/ID
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t       PC_INIT      = 32'h0000_0000,
  parameter word_t       BUBBLE_INSTR = NOP_INSTR,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic [31:0]      iload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             stall,
  input  logic             redirect,
  input  logic [31:0]      redirect_addr,
  input  logic             halt,
  output logic [31:0]      instr_out,
  output logic [31:0]      pc_4_out,
  output logic             instr_valid,
  output logic             flush_out,
  output logic [CNT_W-1:0] fetch_count
);

  fetch_state_t     state_q, state_d;
  word_t            pc_q, pc_d;
  word_t            hold_instr_q, hold_instr_d;
  logic             hold_valid_q, hold_valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  word_t pc_plus4;
  logic  active;
  logic  take_redirect;

  assign pc_plus4      = pc_q + 32'd4;
  assign active        = (state_q == FETCH) || (state_q == HOLD);
  // Halt belongs to an older instruction, so it overrides a same-cycle redirect.
  assign take_redirect = active && redirect && !halt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= FETCH;
      pc_q         <= PC_INIT;
      hold_instr_q <= '0;
      hold_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_valid_q <= hold_valid_d;
      count_q      <= count_d;
    end
  end

  // Saturating increment.
  function automatic logic [CNT_W-1:0] count_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_valid_d = hold_valid_q;
    count_d      = count_q;
    if (active && halt) begin
      state_d      = HALTED;
      hold_valid_d = 1'b0;
    end else if (take_redirect) begin
      // Dropping iaddr's old value abandons any pending response.
      state_d      = FETCH;
      pc_d         = redirect_addr & 32'hFFFF_FFFC;
      hold_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ihit) begin
            if (stall) begin
              state_d      = HOLD;
              hold_instr_d = iload;
              hold_valid_d = 1'b1;
            end else begin
              pc_d    = pc_plus4;
              count_d = count_inc(count_q);
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            state_d      = FETCH;
            pc_d         = pc_plus4;
            hold_valid_d = 1'b0;
            count_d      = count_inc(count_q);
          end
        end
        default: ;  // HALTED: only reset leaves
      endcase
    end
  end

  // Outputs, combinational from state and current inputs.
  always_comb begin
    iREN        = 1'b0;
    iaddr       = pc_q;
    instr_out   = BUBBLE_INSTR;
    instr_valid = 1'b0;
    pc_4_out    = pc_plus4;
    flush_out   = take_redirect;
    unique case (state_q)
      FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          instr_out   = iload;
          instr_valid = !take_redirect;
        end
      end
      HOLD: begin
        instr_out   = hold_instr_q;
        instr_valid = hold_valid_q && !take_redirect;
      end
      default: ;
    endcase
  end

  assign fetch_count = count_q;

endmodule
